// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam int CNT_W = 16;

  // Select width for n channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-deep output register with valid/ready; reloads in the same cycle it drains.
module stream_demux_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign free      = !valid_q || out_ready;

endmodule

// File: rtl/stream_demux_1_n.sv
// Packet-locked 1-to-N stream demultiplexer with a registered slot per channel.
// Optional per-channel beat counters enabled by macro STREAM_DEMUX_CNT_EN.
module stream_demux_1_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = sel_w(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic                    drop_err
`ifdef STREAM_DEMUX_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [N_OUT*CNT_W-1:0]  beat_cnt
`endif
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_q, lock_d, eff_ch;
  logic               drop_err_q, drop_err_d;
  logic               ch_ok, accept;
  logic [N_OUT-1:0]   ch_hit, load, slot_free;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_q     <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Next-state: only accepted beats move the FSM
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: if (!in_last) begin
          state_d = ST_BUSY;
          lock_d  = in_sel;
        end
        ST_BUSY: if (in_last) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: channel decode, handshake, slot loads. Out-of-range channels sink beats.
  always_comb begin
    eff_ch   = (state_q == ST_BUSY) ? lock_q : in_sel;
    ch_hit   = '0;
    ch_ok    = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      ch_hit[k] = (eff_ch == SEL_W'(k));
      if (ch_hit[k]) begin
        ch_ok    = 1'b1;
        in_ready = slot_free[k];
      end
    end
    accept     = in_valid && in_ready;
    load       = ch_hit & {N_OUT{accept}};
    drop_err_d = accept && !ch_ok;
  end

  assign drop_err = drop_err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    logic [DATA_W:0] slot_data;
    stream_demux_slot #(.W(DATA_W + 1)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data ({in_last, in_data}),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (slot_data),
      .free      (slot_free[k])
    );
    assign out_data[k*DATA_W +: DATA_W] = slot_data[DATA_W-1:0];
    assign out_last[k]                  = slot_data[DATA_W];
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [N_OUT*CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; counters wrap naturally
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (cnt_clr)      cnt_d[k*CNT_W +: CNT_W] = '0;
      else if (load[k]) cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Self-checking bench: a 4-channel and a 3-channel demux against a packet/slot reference model.
module tb_stream_demux_1_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic v0, l0, rdy0, drop0;
  logic [7:0]  d0;
  logic [1:0]  s0;
  logic [3:0]  ov0, or0, ol0;
  logic [31:0] od0;

  logic v1, l1, rdy1, drop1;
  logic [7:0]  d1;
  logic [1:0]  s1;
  logic [2:0]  ov1, or1, ol1;
  logic [23:0] od1;

  logic clr;

  stream_demux_1_n #(.DATA_W(8), .N_OUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_last(l0),
    .in_sel(s0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_last(ol0),
    .drop_err(drop0)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_clr(clr), .beat_cnt(bc0)
`endif
  );

  stream_demux_1_n #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_last(l1),
    .in_sel(s1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1),
    .drop_err(drop1)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_clr(clr), .beat_cnt(bc1)
`endif
  );

`ifdef STREAM_DEMUX_CNT_EN
  logic [63:0] bc0;
  logic [47:0] bc1;
  logic [63:0] abc [2];
  assign abc[0] = bc0;
  assign abc[1] = {16'h0, bc1};
`endif

  logic [3:0]  av [2];
  logic [3:0]  al [2];
  logic [31:0] ad [2];
  logic        ar [2];
  logic        adr[2];
  assign av[0] = ov0;  assign av[1] = {1'b0, ov1};
  assign al[0] = ol0;  assign al[1] = {1'b0, ol1};
  assign ad[0] = od0;  assign ad[1] = {8'h0, od1};
  assign ar[0] = rdy0; assign ar[1] = rdy1;
  assign adr[0] = drop0; assign adr[1] = drop1;

  // Reference model: one held beat per channel plus the packet destination lock
  int        nn[2] = '{4, 3};
  bit        m_valid[2][4];
  bit        m_last [2][4];
  logic [7:0] m_data[2][4];
  int        m_cnt  [2][4];
  bit        m_busy [2];
  int        m_lock [2];
  bit        m_drop [2];
  bit        m_acc  [2];

  bit         sv[2];
  bit         sl[2];
  logic [7:0] sd[2];
  int         ss[2];
  logic [3:0] sr[2];
  bit         sclr;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_lock[u] = 0; m_drop[u] = 0; m_acc[u] = 0;
      for (int k = 0; k < 4; k++) begin
        m_valid[u][k] = 0; m_last[u][k] = 0; m_data[u][k] = 8'h00; m_cnt[u][k] = 0;
      end
    end
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      sv[u] = 0; sl[u] = 0; sd[u] = 8'h00; ss[u] = 0; sr[u] = 4'hF;
    end
    sclr = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic tick();
    int ch;
    bit er;
    logic [3:0]  ev, el;
    logic [31:0] ed;
    logic [63:0] ec;
    v0 = sv[0]; d0 = sd[0]; l0 = sl[0]; s0 = ss[0][1:0]; or0 = sr[0];
    v1 = sv[1]; d1 = sd[1]; l1 = sl[1]; s1 = ss[1][1:0]; or1 = sr[1][2:0];
    clr = sclr;
    #1;
    for (int u = 0; u < 2; u++) begin
      ch = m_busy[u] ? m_lock[u] : ss[u];
      er = (ch >= nn[u]) ? 1'b1 : (!m_valid[u][ch] || sr[u][ch]);
      chk($sformatf("in_ready[dut%0d]", u), {63'd0, ar[u]}, {63'd0, er});
      m_acc[u] = sv[u] && er;
      for (int k = 0; k < nn[u]; k++) begin
        if (m_valid[u][k] && sr[u][k]) m_valid[u][k] = 0;
        if (sclr) m_cnt[u][k] = 0;
      end
      m_drop[u] = m_acc[u] && (ch >= nn[u]);
      if (m_acc[u] && ch < nn[u]) begin
        m_valid[u][ch] = 1; m_data[u][ch] = sd[u]; m_last[u][ch] = sl[u];
        if (!sclr) m_cnt[u][ch] = (m_cnt[u][ch] + 1) % 65536;
      end
      if (m_acc[u]) begin
        if (!m_busy[u] && !sl[u]) begin
          m_busy[u] = 1; m_lock[u] = ss[u];
        end else if (m_busy[u] && sl[u]) begin
          m_busy[u] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      ev = '0; el = '0; ed = '0; ec = '0;
      for (int k = 0; k < 4; k++) begin
        ev[k] = m_valid[u][k];
        el[k] = m_last[u][k];
        ed[k*8 +: 8] = m_data[u][k];
        ec[k*16 +: 16] = 16'(m_cnt[u][k]);
      end
      chk($sformatf("out_valid[dut%0d]", u), {60'd0, av[u]}, {60'd0, ev});
      chk($sformatf("out_data[dut%0d]", u),  {32'd0, ad[u]}, {32'd0, ed});
      chk($sformatf("out_last[dut%0d]", u),  {60'd0, al[u]}, {60'd0, el});
      chk($sformatf("drop_err[dut%0d]", u),  {63'd0, adr[u]}, {63'd0, m_drop[u]});
`ifdef STREAM_DEMUX_CNT_EN
      chk($sformatf("beat_cnt[dut%0d]", u), abc[u], ec);
`endif
    end
  endtask

  initial begin
    int beat;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;
    or0 = 4'hF; or1 = 3'h7; clr = 0;
    idle_inputs();
    do_reset(2);

    // After reset: everything empty and ready for any select
    chk("rst_out_valid0", {60'd0, ov0}, 64'd0);
    chk("rst_out_valid1", {61'd0, ov1}, 64'd0);
    chk("rst_out_data0",  {32'd0, od0}, 64'd0);
    chk("rst_drop0",      {63'd0, drop0}, 64'd0);
    for (int s = 0; s < 4; s++) begin
      s0 = 2'(s); s1 = 2'(s);
      #1;
      chk($sformatf("rst_in_ready0_sel%0d", s), {63'd0, rdy0}, 64'd1);
      chk($sformatf("rst_in_ready1_sel%0d", s), {63'd0, rdy1}, 64'd1);
    end
    #1;

    // Single-beat routing to channel 2
    idle_inputs();
    sv[0] = 1; ss[0] = 2; sd[0] = 8'hA5; sl[0] = 1;
    tick();
    chk("single_valid", {60'd0, ov0}, 64'h4);
    chk("single_data",  {56'd0, od0[23:16]}, 64'hA5);
    idle_inputs(); tick();

    // Packet lock: in_sel changes mid-packet are ignored
    for (int i = 0; i < 4; i++) begin
      sv[0] = 1; sd[0] = 8'hD0 + 8'(i); sl[0] = (i == 3); ss[0] = (i == 0) ? 1 : 3;
      tick();
      chk($sformatf("lock_valid_beat%0d", i), {60'd0, ov0}, 64'h2);
    end
    sv[0] = 1; ss[0] = 3; sd[0] = 8'h33; sl[0] = 1;
    tick();
    chk("next_pkt_valid", {60'd0, ov0}, 64'h8);
    idle_inputs(); tick();

    // Backpressure on channel 0, then release
    beat = 0;
    for (int c = 0; c < 20 && beat < 3; c++) begin
      sv[0] = 1; ss[0] = 0; sd[0] = 8'h40 + 8'(beat); sl[0] = (beat == 2);
      sr[0] = (c < 4) ? 4'b1110 : 4'b1111;
      tick();
      if (m_acc[0]) beat++;
    end
    chk("bp_beats_accepted", 64'(beat), 64'd3);
    idle_inputs(); tick();

    // Invalid channel on the 3-channel instance; then confirm FSM is back in IDLE
    for (int i = 0; i < 2; i++) begin
      sv[1] = 1; ss[1] = 3; sd[1] = 8'hE0 + 8'(i); sl[1] = (i == 1);
      tick();
      chk($sformatf("inv_drop%0d", i), {63'd0, drop1}, 64'd1);
      chk($sformatf("inv_valid%0d", i), {61'd0, ov1}, 64'd0);
    end
    sv[1] = 1; ss[1] = 0; sd[1] = 8'h5A; sl[1] = 1;
    tick();
    chk("inv_after_valid", {61'd0, ov1}, 64'h1);
    chk("inv_after_drop",  {63'd0, drop1}, 64'd0);
    idle_inputs(); tick();

    // Reset mid-packet, held beats discarded; fresh packet routes to ch0
    sr[0] = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      sv[0] = 1; ss[0] = 1; sd[0] = 8'h70 + 8'(i); sl[0] = 0;
      tick();
    end
    do_reset(1);
    chk("midrst_valid0", {60'd0, ov0}, 64'd0);
    chk("midrst_valid1", {61'd0, ov1}, 64'd0);
    idle_inputs();
    sv[0] = 1; ss[0] = 0; sd[0] = 8'h99; sl[0] = 1;
    tick();
    chk("midrst_new_valid", {60'd0, ov0}, 64'h1);
    chk("midrst_new_data",  {56'd0, od0[7:0]}, 64'h99);
    idle_inputs(); tick();

    // Randomised traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 2; u++) begin
        sv[u] = ($urandom_range(0, 3) != 0);
        sl[u] = ($urandom_range(0, 3) == 0);
        sd[u] = 8'($urandom);
        ss[u] = $urandom_range(0, 3);
        sr[u] = 4'($urandom);
      end
      sclr = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle_inputs(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
